// File: rtl/mem_op_engine.sv
// Two-bank memory datapath: a sequencer reads each word of an input-bank
// address range, combines its two halves and writes the result to the output bank.
// Ports:
//   clk, rst                     clock, async active-high reset
//   wr_en, wr_addr, wr_data      host write into input bank (IDLE only)
//   start, mode                  launch a run (sampled in IDLE), operation select
//   first_addr, last_addr        inclusive run range, wraps through DEPTH-1
//   rd_sel, rd_addr, rd_data     host read port (1 = input bank), 1-cycle latency
//   busy, done, ovf              run status; ovf is sticky per run
`timescale 1ns/1ps
module mem_op_engine #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic              rd_sel,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  localparam int H     = DATA_W / 2;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   C_ONE = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    FIN
  } state_t;

  state_t            state_q;
  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] cur_q;
  logic [ADDR_W:0]   n_q;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   n_d;
  logic [ADDR_W:0]   cnt_d;
  logic [DATA_W-1:0] rdat_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              busy_q;
  logic              done_q;
  logic              ovf_q;

  logic [DATA_W-1:0] in_mem  [DEPTH];
  logic [DATA_W-1:0] out_mem [DEPTH];

  logic [H-1:0]      hi;
  logic [H-1:0]      lo;
  logic [H:0]        sum;
  logic [H+1:0]      dbl;
  logic [H-1:0]      dif;
  logic [DATA_W-1:0] prod;
  logic [DATA_W-1:0] res_d;
  logic              sat_d;

  assign hi   = rdat_q[DATA_W-1:H];
  assign lo   = rdat_q[H-1:0];
  assign sum  = {1'b0, hi} + {1'b0, lo};
  assign dbl  = {sum, 1'b0};
  assign dif  = (hi >= lo) ? (hi - lo) : (lo - hi);
  assign prod = {{H{1'b0}}, hi} * {{H{1'b0}}, lo};

  // Range length is taken modulo DEPTH, so first > last wraps.
  assign n_d   = {1'b0, last_addr - first_addr} + C_ONE;
  assign cnt_d = cnt_q + C_ONE;

  always_comb begin
    res_d = '0;
    sat_d = 1'b0;
    unique case (mode_q)
      2'b00: res_d = {{(H-1){1'b0}}, sum};
      2'b01: res_d = {{H{1'b0}}, dif};
      2'b10: res_d = prod;
      2'b11: begin
        // Doubling overflows H+1 bits exactly when its top bit is set.
        if (dbl[H+1]) begin
          res_d = {{(H-1){1'b0}}, {(H+1){1'b1}}};
          sat_d = 1'b1;
        end else begin
          res_d = {{(H-1){1'b0}}, dbl[H:0]};
        end
      end
    endcase
  end

  // Bank storage is not reset; writes are suppressed while rst is high.
  always_ff @(posedge clk) begin
    if (!rst && wr_en && state_q == IDLE)
      in_mem[wr_addr] <= wr_data;
    if (!rst && state_q == WR)
      out_mem[cur_q] <= res_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= 2'b00;
      cur_q     <= '0;
      n_q       <= '0;
      cnt_q     <= '0;
      rdat_q    <= '0;
      rd_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      // Non-blocking read: a same-cycle output write returns the old word.
      rd_data_q <= rd_sel ? in_mem[rd_addr] : out_mem[rd_addr];
      done_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            mode_q  <= mode;
            cur_q   <= first_addr;
            n_q     <= n_d;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RD;
          end
        end
        RD: begin
          rdat_q  <= in_mem[cur_q];
          state_q <= WR;
        end
        WR: begin
          ovf_q <= ovf_q | sat_d;
          if (cnt_d == n_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            cnt_q   <= cnt_d;
            cur_q   <= cur_q + A_ONE;
            state_q <= RD;
          end
        end
        FIN: state_q <= IDLE;
      endcase
    end
  end

  assign rd_data = rd_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_mem_op_engine.sv
// Bench for mem_op_engine: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a schedule-based model.
`timescale 1ns/1ps
module tb_mem_op_engine;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int H     = DW / 2;
  localparam int HM    = (1 << H) - 1;
  localparam int SATV  = (1 << (H + 1)) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic [1:0]    mode = '0;
  logic [AW-1:0] first_addr = '0;
  logic [AW-1:0] last_addr = '0;
  logic          rd_sel = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic          ovf;

  mem_op_engine #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .mode(mode),
    .first_addr(first_addr), .last_addr(last_addr),
    .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic void op(input int m, input int w,
                             output int r, output bit s);
    int hi, lo;
    hi = (w >> H) & HM;
    lo = w & HM;
    s  = 0;
    case (m)
      0: r = hi + lo;
      1: r = (hi > lo) ? hi - lo : lo - hi;
      2: r = hi * lo;
      default: begin
        r = 2 * (hi + lo);
        if (r > SATV) begin
          r = SATV;
          s = 1;
        end
      end
    endcase
  endfunction

  // Model: per run, results are precomputed from the input bank at launch;
  // word k lands in the output bank at the end of cycle T+2+2k.
  logic [DW-1:0] in_m  [DEPTH];
  logic [DW-1:0] out_m [DEPTH];
  bit            in_v  [DEPTH];
  bit            out_v [DEPTH];
  int            ra [DEPTH];
  int            rv [DEPTH];
  bit            rs [DEPTH];
  int            r  = -1;
  int            rn = 0;
  bit            e_busy = 0;
  bit            e_done = 0;
  bit            e_ovf  = 0;
  logic [DW-1:0] e_rd   = '0;
  bit            e_rd_v = 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      r = -1; e_busy = 0; e_done = 0; e_ovf = 0;
      e_rd = '0; e_rd_v = 1;
    end else begin
      e_rd_v = rd_sel ? in_v[rd_addr] : out_v[rd_addr];
      e_rd   = rd_sel ? in_m[rd_addr] : out_m[rd_addr];
      if (r < 0) begin
        if (wr_en) begin
          in_m[wr_addr] = wr_data;
          in_v[wr_addr] = 1;
        end
        if (start) begin
          rn = ((int'(last_addr) - int'(first_addr) + DEPTH) % DEPTH) + 1;
          for (int k = 0; k < rn; k++) begin
            ra[k] = (int'(first_addr) + k) % DEPTH;
            op(int'(mode), int'(in_m[ra[k]]), rv[k], rs[k]);
          end
          r = 0; e_busy = 1; e_ovf = 0;
        end
      end else begin
        r++;
        if (r % 2 == 0 && r <= 2 * rn) begin
          out_m[ra[r/2-1]] = DW'(rv[r/2-1]);
          out_v[ra[r/2-1]] = 1;
          e_ovf = e_ovf | rs[r/2-1];
        end
        if (r == 2 * rn) begin
          e_busy = 0; e_done = 1;
        end else if (r == 2 * rn + 1) begin
          e_done = 0; r = -1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      if (e_rd_v) chk("rd_data", rd_data, e_rd);
      if (!e_busy) chk("ovf", ovf, e_ovf);
    end
  end

  int bc;

  task automatic wr(input int a, input int d);
    wr_en = 1; wr_addr = AW'(a); wr_data = DW'(d);
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic rd(input bit s, input int a, output logic [DW-1:0] d);
    rd_sel = s; rd_addr = AW'(a);
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic wait_done(output int lat);
    lat = 1; bc = 0;
    while (!done && lat < 200) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      n_chk++; n_err++;
      $display("FAIL timeout: done not seen after %0d cycles", lat);
    end
    @(negedge clk);
  endtask

  task automatic run(input int m, input int f, input int l, output int lat);
    mode = 2'(m); first_addr = AW'(f); last_addr = AW'(l); start = 1;
    @(negedge clk);
    start = 0;
    wait_done(lat);
  endtask

  initial begin
    logic [DW-1:0] d;
    int lat, g;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_rd", rd_data, 0);
    chk_en = 1;
    rst = 0;
    @(negedge clk);

    for (int i = 0; i < DEPTH; i++)
      wr(i, ((2 * i + 1) << 8) | (2 * i + 2));

    run(0, 0, 15, lat);
    chk("lat_full", lat, 33);
    chk("busy_cycles", bc, 32);
    rd(0, 0, d); chk("m0_out0", d, 'h0003);
    rd(0, 1, d); chk("m0_out1", d, 'h0007);

    wr(5, 'h7F80);
    run(3, 5, 5, lat);
    chk("lat_one", lat, 3);
    rd(0, 5, d); chk("m3_nosat", d, 'h01FE);
    chk("ovf_clear", ovf, 0);
    wr(5, 'hFFFF);
    run(3, 5, 5, lat);
    rd(0, 5, d); chk("m3_sat", d, 'h01FF);
    chk("ovf_set", ovf, 1);
    run(0, 5, 5, lat);
    chk("ovf_restart", ovf, 0);
    rd(0, 5, d); chk("m0_ffff", d, 'h01FE);

    wr(14, 'h0509);
    wr(15, 'h0905);
    run(1, 14, 1, lat);
    chk("lat_wrap", lat, 9);
    rd(0, 14, d); chk("wrap14", d, 'h0004);
    rd(0, 15, d); chk("wrap15", d, 'h0004);
    rd(0, 0, d);  chk("wrap0", d, 'h0001);
    rd(0, 1, d);  chk("wrap1", d, 'h0001);
    rd(0, 2, d);  chk("untouched2", d, 'h000B);
    rd(0, 13, d); chk("untouched13", d, 'h0037);

    wr(3, 'hFFFF);
    mode = 2'd2; first_addr = 4'd3; last_addr = 4'd3; start = 1;
    @(negedge clk);
    start = 0; wr_en = 1; wr_addr = 4'd3; wr_data = 'h1234;
    @(negedge clk);
    wr_en = 0;
    wait_done(lat);
    rd(0, 3, d); chk("m2_ffff", d, 'hFE01);
    rd(1, 3, d); chk("busy_wr_drop", d, 'hFFFF);

    // Abort a 16-word mode-1 run just after its third write.
    mode = 2'd1; first_addr = 4'd0; last_addr = 4'd15; start = 1;
    @(negedge clk);
    @(posedge clk);
    #1 start = 0;
    repeat (6) @(posedge clk);
    #1 rst = 1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ovf", ovf, 0);
    chk("abort_rd", rd_data, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    rd(0, 2, d); chk("abort_new2", d, 'h0001);
    rd(0, 3, d); chk("abort_old3", d, 'hFE01);
    rd(0, 4, d); chk("abort_old4", d, 'h0013);
    run(0, 0, 15, lat);
    chk("lat_after_rst", lat, 33);
    rd(0, 3, d); chk("fresh3", d, 'h01FE);

    mode = 2'd0; first_addr = 4'd0; last_addr = 4'd15; start = 1;
    g = 0;
    while (!done && g < 200) begin
      rd_sel = 1'($urandom); rd_addr = AW'($urandom);
      @(negedge clk);
      g++;
    end
    chk("held_first_done", done, 1);
    g = 0;
    do begin
      rd_sel = 1'($urandom); rd_addr = AW'($urandom);
      @(negedge clk);
      g++;
    end while (!done && g < 200);
    chk("held_gap", g, 34);
    start = 0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 1500; i++) begin
      rd_sel     = 1'($urandom);
      rd_addr    = AW'($urandom);
      wr_en      = ($urandom % 3) == 0;
      wr_addr    = AW'($urandom);
      wr_data    = DW'($urandom);
      start      = ($urandom % 6) == 0;
      mode       = 2'($urandom);
      first_addr = AW'($urandom);
      last_addr  = AW'($urandom);
      @(negedge clk);
    end
    wr_en = 0; start = 0;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
